if_id_hazard_stage: RTL and testbench

IF/ID pipeline register with integrated load-use hazard detection and branch/jump flush, sitting directly upstream of the ID/EX register.
- Captures the fetched instruction and PC+4 each cycle.
- Holds both values and requests a control bubble into ID/EX when an EX-stage load feeds the decoding instruction.
- Squashes the IF/ID contents to a NOP on a taken branch or jump.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/if_id_hazard_stage_pkg.sv | 29 ++
 rtl/if_id_hazard_stage_hazard_detect.sv | 22 ++
 rtl/if_id_hazard_stage.sv | 100 ++++++++++
 tb/tb_if_id_hazard_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_hazard_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register with load-use hazard detection:
// MIPS opcode constants, the NOP encoding and the stall FSM state type.
package if_id_hazard_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [31:0] NOP = 32'h0;

  // Width of the stall down-counter; it covers the legal STALL_CYCLES range of 1..15.
  localparam int STALL_CNT_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // These instructions read rt as a source operand, not as a destination.
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
           (opcode == OP_SW)    || (opcode == OP_SH)  || (opcode == OP_SB);
  endfunction

endpackage

// File: rtl/if_id_hazard_stage_hazard_detect.sv
// Combinational load-use hazard check between the instruction in ID and a load in EX.
module if_id_hazard_stage_hazard_detect
  import if_id_hazard_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  logic uses_rt;

  assign uses_rt = reads_rt(opcode);

  // A load into $0 never produces a value that a consumer could wait on.
  assign hazard = valid && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register: captures instruction and PC+4, holds and bubbles on
// load-use hazards, squashes on taken branches, and counts stall/flush events.
module if_id_hazard_stage
  import if_id_hazard_stage_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      IF_Instruction,
  input  logic [31:0]      IF_PCAddResult,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Instruction16_20,
  input  logic             Flush,
  output logic [31:0]      ID_Instruction,
  output logic [31:0]      ID_PCAddResult,
  output logic             ID_Valid,
  output logic             PCWrite,
  output logic             ID_Bubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  state_t                 state;
  logic [STALL_CNT_W-1:0] cnt;
  logic                   hazard;
  logic                   bubble;

  if_id_hazard_stage_hazard_detect u_hazard_detect (
    .opcode      (ID_Instruction[31:26]),
    .rs          (ID_Instruction[25:21]),
    .rt          (ID_Instruction[20:16]),
    .valid       (ID_Valid),
    .ex_mem_read (EX_MemRead),
    .ex_rt       (EX_Instruction16_20),
    .hazard      (hazard)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bubble = 1'b0;
    if (!Flush) bubble = (state == STALL) || hazard;
  end

  // Flush wins over any stall so the PC is free to load the branch target.
  assign ID_Bubble = bubble;
  assign PCWrite   = !bubble;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ID_Instruction <= NOP;
      ID_PCAddResult <= 32'h0;
      ID_Valid       <= 1'b0;
      state          <= RUN;
      cnt            <= '0;
    end else if (Flush) begin
      // Keep the PC+4 of the squashed slot; only the instruction is killed.
      ID_Instruction <= NOP;
      ID_Valid       <= 1'b0;
      ID_PCAddResult <= IF_PCAddResult;
      state          <= RUN;
      cnt            <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            if (STALL_CYCLES > 1) begin
              state <= STALL;
              cnt   <= STALL_CNT_W'(STALL_CYCLES - 1);
            end
          end else begin
            ID_Instruction <= IF_Instruction;
            ID_PCAddResult <= IF_PCAddResult;
            ID_Valid       <= 1'b1;
          end
        end
        STALL: begin
          // The hazard is not re-checked here; the hold length is fixed by memory latency.
          cnt <= cnt - 1'b1;
          if (cnt == STALL_CNT_W'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (bubble && (StallCount != '1)) StallCount <= StallCount + 1'b1;
      if (Flush && (FlushCount != '1)) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed bench for if_id_hazard_stage: three instances (1-cycle stall, 3-cycle stall,
// 2-bit counters) share one stimulus stream; each scenario checks the relevant instance.
module tb_if_id_hazard_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        flush;

  // Instance a: STALL_CYCLES=1, CNT_W=16
  logic [31:0] a_instr, a_pc;
  logic        a_valid, a_pcw, a_bub;
  logic [15:0] a_scnt, a_fcnt;
  // Instance b: STALL_CYCLES=3, CNT_W=16
  logic [31:0] b_instr, b_pc;
  logic        b_valid, b_pcw, b_bub;
  logic [15:0] b_scnt, b_fcnt;
  // Instance c: STALL_CYCLES=1, CNT_W=2
  logic [31:0] c_instr, c_pc;
  logic        c_valid, c_pcw, c_bub;
  logic [1:0]  c_scnt, c_fcnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  if_id_hazard_stage #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .Clk(clk), .Reset(rst), .IF_Instruction(if_instr), .IF_PCAddResult(if_pc),
    .EX_MemRead(ex_mem_read), .EX_Instruction16_20(ex_rt), .Flush(flush),
    .ID_Instruction(a_instr), .ID_PCAddResult(a_pc), .ID_Valid(a_valid),
    .PCWrite(a_pcw), .ID_Bubble(a_bub), .StallCount(a_scnt), .FlushCount(a_fcnt)
  );

  if_id_hazard_stage #(.STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .Clk(clk), .Reset(rst), .IF_Instruction(if_instr), .IF_PCAddResult(if_pc),
    .EX_MemRead(ex_mem_read), .EX_Instruction16_20(ex_rt), .Flush(flush),
    .ID_Instruction(b_instr), .ID_PCAddResult(b_pc), .ID_Valid(b_valid),
    .PCWrite(b_pcw), .ID_Bubble(b_bub), .StallCount(b_scnt), .FlushCount(b_fcnt)
  );

  if_id_hazard_stage #(.STALL_CYCLES(1), .CNT_W(2)) dut_c (
    .Clk(clk), .Reset(rst), .IF_Instruction(if_instr), .IF_PCAddResult(if_pc),
    .EX_MemRead(ex_mem_read), .EX_Instruction16_20(ex_rt), .Flush(flush),
    .ID_Instruction(c_instr), .ID_PCAddResult(c_pc), .ID_Valid(c_valid),
    .PCWrite(c_pcw), .ID_Bubble(c_bub), .StallCount(c_scnt), .FlushCount(c_fcnt)
  );

  // Inputs change 1 time unit after a rising edge; checks happen another unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    if_instr = 32'h0; if_pc = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd8;
    if_instr = 32'h01095020; if_pc = 32'h4;
    tick(); tick();
    compared++; if (a_instr !== 32'h0) begin mismatched++; $display("FAIL reset_instr: got %h want %h", a_instr, 32'h0); end
    compared++; if (a_pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h want %h", a_pc, 32'h0); end
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    compared++; if (a_pcw !== 1'b1 || a_bub !== 1'b0) begin mismatched++; $display("FAIL reset_ctrl: got pcwrite=%b bubble=%b want 1/0", a_pcw, a_bub); end
    compared++; if (a_scnt !== 16'd0 || a_fcnt !== 16'd0) begin mismatched++; $display("FAIL reset_counts: got %0d/%0d want 0/0", a_scnt, a_fcnt); end
    rst = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
  endtask

  task automatic test_fetch();
    if_instr = 32'h20080005; if_pc = 32'h4;
    tick();
    if_instr = 32'h20090007; if_pc = 32'h8;
    compared++; if (a_instr !== 32'h20080005 || a_pc !== 32'h4 || a_valid !== 1'b1) begin mismatched++; $display("FAIL fetch1: got %h @%h v=%b want 20080005 @4 v=1", a_instr, a_pc, a_valid); end
    compared++; if (a_pcw !== 1'b1) begin mismatched++; $display("FAIL fetch1_pcwrite: got %b want 1", a_pcw); end
    tick();
    compared++; if (a_instr !== 32'h20090007 || a_pc !== 32'h8 || a_valid !== 1'b1) begin mismatched++; $display("FAIL fetch2: got %h @%h v=%b want 20090007 @8 v=1", a_instr, a_pc, a_valid); end
    compared++; if (a_pcw !== 1'b1 || a_scnt !== 16'd0) begin mismatched++; $display("FAIL fetch2_state: got pcwrite=%b stalls=%0d want 1/0", a_pcw, a_scnt); end
  endtask

  task automatic test_load_use();
    if_instr = 32'h01095020; if_pc = 32'hC;     // add $10,$8,$9
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd8; if_instr = 32'h11111111; if_pc = 32'h10;
    #1;
    compared++; if (a_pcw !== 1'b0 || a_bub !== 1'b1) begin mismatched++; $display("FAIL lu_stall: got pcwrite=%b bubble=%b want 0/1", a_pcw, a_bub); end
    tick();
    ex_mem_read = 1'b0;                          // the bubble is now in EX
    #1;
    compared++; if (a_instr !== 32'h01095020 || a_pc !== 32'hC) begin mismatched++; $display("FAIL lu_hold: got %h @%h want 01095020 @c", a_instr, a_pc); end
    compared++; if (a_pcw !== 1'b1 || a_bub !== 1'b0 || a_scnt !== 16'd1) begin mismatched++; $display("FAIL lu_resume: got pcwrite=%b bubble=%b stalls=%0d want 1/0/1", a_pcw, a_bub, a_scnt); end
    tick();
    compared++; if (a_instr !== 32'h11111111 || a_pc !== 32'h10) begin mismatched++; $display("FAIL lu_next: got %h @%h want 11111111 @10", a_instr, a_pc); end
  endtask

  task automatic test_operand_match();
    if_instr = 32'h00005020; if_pc = 32'h14;    // add $10,$0,$0
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd0;
    #1;
    compared++; if (a_bub !== 1'b0 || a_pcw !== 1'b1) begin mismatched++; $display("FAIL zero_reg: got bubble=%b pcwrite=%b want 0/1", a_bub, a_pcw); end
    ex_mem_read = 1'b0; if_instr = 32'h212A0001; if_pc = 32'h18;  // addi $10,$9,1
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9;
    #1;
    compared++; if (a_bub !== 1'b1 || a_pcw !== 1'b0) begin mismatched++; $display("FAIL rs_match: got bubble=%b pcwrite=%b want 1/0", a_bub, a_pcw); end
    tick();
    ex_mem_read = 1'b0; if_instr = 32'h3C090001; if_pc = 32'h1C;  // lui $9,1
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9;
    #1;
    compared++; if (a_bub !== 1'b0 || a_pcw !== 1'b1) begin mismatched++; $display("FAIL lui_rt: got bubble=%b pcwrite=%b want 0/1", a_bub, a_pcw); end
    ex_mem_read = 1'b0; if_instr = 32'hAC890000; if_pc = 32'h20;  // sw $9,0($4)
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9;
    #1;
    compared++; if (a_bub !== 1'b1) begin mismatched++; $display("FAIL sw_rt: got bubble=%b want 1", a_bub); end
    tick();
    ex_mem_read = 1'b0;
    #1;
    compared++; if (a_scnt !== 16'd3) begin mismatched++; $display("FAIL operand_stalls: got %0d want 3", a_scnt); end
  endtask

  task automatic test_multi_stall_flush();
    apply_reset();
    if_instr = 32'h01095020; if_pc = 32'h4;
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd8; if_instr = 32'h22222222; if_pc = 32'h8;
    #1;
    compared++; if (b_bub !== 1'b1) begin mismatched++; $display("FAIL ms_cycle1: got bubble=%b want 1", b_bub); end
    tick();
    ex_mem_read = 1'b0;                          // STALL must ignore the EX inputs
    #1;
    compared++; if (b_bub !== 1'b1 || b_pcw !== 1'b0 || b_scnt !== 16'd1) begin mismatched++; $display("FAIL ms_cycle2: got bubble=%b pcwrite=%b stalls=%0d want 1/0/1", b_bub, b_pcw, b_scnt); end
    tick();
    compared++; if (b_bub !== 1'b1 || b_instr !== 32'h01095020) begin mismatched++; $display("FAIL ms_cycle3: got bubble=%b instr=%h want 1/01095020", b_bub, b_instr); end
    tick();
    compared++; if (b_bub !== 1'b0 || b_pcw !== 1'b1 || b_scnt !== 16'd3) begin mismatched++; $display("FAIL ms_done: got bubble=%b pcwrite=%b stalls=%0d want 0/1/3", b_bub, b_pcw, b_scnt); end
    ex_mem_read = 1'b1;
    tick();                                      // enters STALL, stalls=4
    ex_mem_read = 1'b0; flush = 1'b1; if_pc = 32'h30;
    #1;
    compared++; if (b_pcw !== 1'b1 || b_bub !== 1'b0) begin mismatched++; $display("FAIL msf_ctrl: got pcwrite=%b bubble=%b want 1/0", b_pcw, b_bub); end
    tick();
    flush = 1'b0; if_pc = 32'h34;
    #1;
    compared++; if (b_instr !== 32'h0 || b_valid !== 1'b0 || b_pc !== 32'h30) begin mismatched++; $display("FAIL msf_squash: got %h v=%b @%h want 0 v=0 @30", b_instr, b_valid, b_pc); end
    compared++; if (b_fcnt !== 16'd1 || b_scnt !== 16'd4 || b_bub !== 1'b0) begin mismatched++; $display("FAIL msf_state: got flushes=%0d stalls=%0d bubble=%b want 1/4/0", b_fcnt, b_scnt, b_bub); end
    tick();
    compared++; if (b_instr !== 32'h22222222 || b_valid !== 1'b1) begin mismatched++; $display("FAIL msf_resume: got %h v=%b want 22222222 v=1", b_instr, b_valid); end
  endtask

  task automatic test_flush_beats_hazard();
    apply_reset();
    if_instr = 32'h01095020; if_pc = 32'h4;
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd8; flush = 1'b1; if_pc = 32'h40;
    #1;
    compared++; if (a_pcw !== 1'b1 || a_bub !== 1'b0) begin mismatched++; $display("FAIL fh_ctrl: got pcwrite=%b bubble=%b want 1/0", a_pcw, a_bub); end
    tick();
    flush = 1'b0; ex_mem_read = 1'b0;
    compared++; if (a_instr !== 32'h0 || a_valid !== 1'b0 || a_pc !== 32'h40) begin mismatched++; $display("FAIL fh_squash: got %h v=%b @%h want 0 v=0 @40", a_instr, a_valid, a_pc); end
    compared++; if (a_scnt !== 16'd0 || a_fcnt !== 16'd1) begin mismatched++; $display("FAIL fh_counts: got stalls=%0d flushes=%0d want 0/1", a_scnt, a_fcnt); end
  endtask

  task automatic test_saturate_and_reset();
    apply_reset();
    if_instr = 32'h01095020; if_pc = 32'h4;
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    tick(); tick(); tick();
    compared++; if (c_scnt !== 2'd3) begin mismatched++; $display("FAIL sat_reach: got %0d want 3", c_scnt); end
    tick(); tick();
    compared++; if (c_scnt !== 2'd3) begin mismatched++; $display("FAIL sat_hold: got %0d want 3", c_scnt); end
    // dut_b: RUN->STALL(2)->STALL(1)->RUN->STALL(2)->STALL(1), five bubble edges
    compared++; if (b_bub !== 1'b1 || b_scnt !== 16'd5) begin mismatched++; $display("FAIL pre_reset_stall: got bubble=%b stalls=%0d want 1/5", b_bub, b_scnt); end
    #2 rst = 1'b1;
    #1;
    compared++; if (b_instr !== 32'h0 || b_valid !== 1'b0 || b_scnt !== 16'd0) begin mismatched++; $display("FAIL async_reset: got %h v=%b stalls=%0d want 0 v=0 0", b_instr, b_valid, b_scnt); end
    compared++; if (b_pcw !== 1'b1 || b_bub !== 1'b0) begin mismatched++; $display("FAIL async_reset_ctrl: got pcwrite=%b bubble=%b want 1/0", b_pcw, b_bub); end
    rst = 1'b0; ex_mem_read = 1'b0; if_instr = 32'h33333333; if_pc = 32'h50;
    tick();
    compared++; if (b_instr !== 32'h33333333 || b_pc !== 32'h50 || b_valid !== 1'b1) begin mismatched++; $display("FAIL post_reset_load: got %h @%h v=%b want 33333333 @50 v=1", b_instr, b_pc, b_valid); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_use();
    test_operand_match();
    test_multi_stall_flush();
    test_flush_beats_hazard();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
